// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and round-robin search helper for the
// rr_mux_arbiter slice (arbiter top plus mux_16x1 datapath).
package mux_arb_pkg;

    localparam int N                = 16;
    localparam int SEL_W            = 4;
    localparam int CNT_W            = 8;
    localparam int MAX_HOLD_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    // Scan from last_ptr+1 upward, wrapping through last_ptr itself.
    // Returns {found, index}; index is don't-care when found is 0.
    function automatic logic [SEL_W:0] rr_next(
        input logic [N-1:0]     req,
        input logic [SEL_W-1:0] last_ptr
    );
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = last_ptr;
        for (int k = 1; k <= N; k++) begin
            cand = last_ptr + SEL_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/mux_16x1.sv
// Single-bit 16:1 multiplexer datapath.
// Ports: in (16 data bits), sel (4-bit select), o (selected bit).
module mux_16x1
    import mux_arb_pkg::*;
(
    input  logic [N-1:0]     in,
    input  logic [SEL_W-1:0] sel,
    output logic             o
);

    assign o = in[sel];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 16:1 bit mux among 16 requesters; holds a
// grant for up to MAX_HOLD accepted beats, then rotates.
// Ports: clk, rst (sync, active-high), req[15:0], in[15:0], ready,
//        sel[3:0], grant[15:0], o, out_valid, busy,
//        lock (only when RR_ARB_LOCK_EN is defined: suppresses forced rotation).
module rr_mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     in,
    input  logic             ready,
`ifdef RR_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [SEL_W-1:0] sel,
    output logic [N-1:0]     grant,
    output logic             o,
    output logic             out_valid,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [SEL_W-1:0]   last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               serving;
    logic               accept;
    logic               at_max;
    logic               hold_ok;
    logic               force_rel;
    logic               drop_rel;
    logic               rel;
    logic [SEL_W-1:0]   search_ptr;
    logic               found;
    logic [SEL_W-1:0]   win;

    assign serving   = (state_q == SERVE);
    assign out_valid = serving && req[sel_q];
    assign busy      = serving;
    assign sel       = sel_q;
    assign grant     = grant_q;
    assign accept    = out_valid && ready;
    assign at_max    = (cnt_q == CNT_W'(MAX_HOLD - 1));

`ifdef RR_ARB_LOCK_EN
    assign hold_ok = !lock;
`else
    assign hold_ok = 1'b1;
`endif

    assign force_rel = accept && at_max && hold_ok;
    assign drop_rel  = serving && !req[sel_q];
    assign rel       = force_rel || drop_rel;

    // A releasing grantee becomes the new pointer for this same-cycle search.
    assign search_ptr    = rel ? sel_q : last_ptr_q;
    assign {found, win}  = rr_next(req, search_ptr);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        last_ptr_d = last_ptr_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = SERVE;
                    sel_d        = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    cnt_d        = '0;
                end
            end
            SERVE: begin
                if (rel) begin
                    last_ptr_d = sel_q;
                    cnt_d      = '0;
                    if (found) begin
                        sel_d        = win;
                        grant_d      = '0;
                        grant_d[win] = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (accept && !at_max) begin
                    // at_max without release only occurs under lock: saturate.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            grant_q    <= '0;
            last_ptr_q <= SEL_W'(N - 1);
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            last_ptr_q <= last_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    mux_16x1 u_mux (
        .in  (in),
        .sel (sel_q),
        .o   (o)
    );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with a queue of expected accepted beats.
// Define RR_ARB_LOCK_EN to include the lock scenario.
module tb_rr_mux_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic [15:0] in_v;
    logic        ready;
`ifdef RR_ARB_LOCK_EN
    logic        lock;
`endif
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        o;
    logic        out_valid;
    logic        busy;

    typedef struct {
        logic [3:0] s;
        logic [7:0] c;
    } beat_t;

    beat_t q[$];
    int    total  = 0;
    int    passed = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in        (in_v),
        .ready     (ready),
`ifdef RR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .sel       (sel),
        .grant     (grant),
        .o         (o),
        .out_valid (out_valid),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input int s, input int c);
        beat_t b;
        b.s = 4'(s);
        b.c = 8'(c);
        q.push_back(b);
    endtask

    // Each cycle must present a beat (ready=1 held): no bubbles allowed.
    task automatic serve();
        beat_t      b;
        logic [15:0] g;
        while (q.size() > 0) begin
            b = q.pop_front();
            g = 16'h0;
            g[b.s] = 1'b1;
            chk("beat_valid", 32'(out_valid), 32'd1);
            chk("beat_sel", 32'(sel), 32'(b.s));
            chk("beat_grant", 32'(grant), 32'(g));
            chk("beat_o", 32'(o), 32'(in_v[b.s]));
            chk("beat_cnt", 32'(dut.cnt_q), 32'(b.c));
            in_v = 16'($urandom);
            #1;
            step();
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = 16'h0;
        ready = 1'b0;
        step();
        step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        rst   = 1'b1;
        req   = 16'h0;
        ready = 1'b0;
        in_v  = 16'h5a3c;
`ifdef RR_ARB_LOCK_EN
        lock  = 1'b0;
`endif

        // Single requester: 1-cycle latency, 8 beats, seamless re-grant.
        do_reset();
        rst = 1'b0; req = 16'h0001; ready = 1'b1;
        step();
        chk("lat_grant", 32'(grant), 32'h0001);
        chk("lat_sel", 32'(sel), 32'h0);
        chk("lat_valid", 32'(out_valid), 32'h1);
        for (int k = 0; k < 16; k++) push(0, k % 8);
        serve();

        // Rotation 0 -> 5 -> 10 -> 15 -> 0.
        do_reset();
        rst = 1'b0; req = 16'h8421; ready = 1'b1;
        step();
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < 8; k++) push((r * 5) % 20, k);
        serve();

        // Backpressure on requester 3.
        do_reset();
        rst = 1'b0; req = 16'h0008; ready = 1'b0;
        step();
        for (int k = 0; k < 20; k++) begin
            chk("bp_grant", 32'(grant), 32'h0008);
            chk("bp_cnt", 32'(dut.cnt_q), 32'h0);
            step();
        end
        ready = 1'b1;
        for (int k = 0; k < 8; k++) push(3, k);
        serve();

        // Requester 7 drops after 2 beats; 9 takes over, then idle.
        do_reset();
        rst = 1'b0; req = 16'h0280; ready = 1'b1;
        step();
        push(7, 0); push(7, 1);
        serve();
        req = 16'h0200;
        #1;
        chk("drop_valid", 32'(out_valid), 32'h0);
        step();
        chk("drop_grant", 32'(grant), 32'h0200);
        chk("drop_sel", 32'(sel), 32'h9);
        chk("drop_cnt", 32'(dut.cnt_q), 32'h0);
        chk("drop_valid2", 32'(out_valid), 32'h1);
        req = 16'h0;
        step();
        chk("idle_grant", 32'(grant), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_sel", 32'(sel), 32'h9);

        // Reset mid-grant; last_ptr returns to 15.
        do_reset();
        rst = 1'b0; req = 16'h0004; ready = 1'b1;
        step();
        for (int k = 0; k < 8; k++) push(2, k);
        for (int k = 0; k < 3; k++) push(2, k);
        serve();
        chk("mid_cnt", 32'(dut.cnt_q), 32'h3);
        rst = 1'b1;
        step();
        chk("mid_grant", 32'(grant), 32'h0);
        chk("mid_valid", 32'(out_valid), 32'h0);
        rst = 1'b0; req = 16'h000c;
        step();
        chk("ptr_sel", 32'(sel), 32'h2);
        chk("ptr_grant", 32'(grant), 32'h0004);

`ifdef RR_ARB_LOCK_EN
        // Lock holds requester 0 for 30 beats, release after unlock.
        do_reset();
        lock = 1'b1;
        rst = 1'b0; req = 16'h0003; ready = 1'b1;
        step();
        for (int k = 0; k < 30; k++) push(0, (k < 7) ? k : 7);
        serve();
        lock = 1'b0;
        push(0, 7); push(1, 0);
        serve();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
